// File: rtl/quant_serializer.sv
// quant_serializer: takes a signed maxpool word and picks an oprec-bit window
// ending at bit msbidx. The window is rounded half-up and saturated, then
// shifted out MSB first as a serial bit stream with valid/done markers.
// A new word may start in the cycle that carries the last bit of the previous one.
module quant_serializer #(
    parameter int N    = 32,
    parameter int IDXW = 5,
    parameter int PRW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [N-1:0]    I,
    input  logic [IDXW-1:0] msbidx,
    input  logic [PRW-1:0]  oprec,
    output logic            rdy,
    output logic            out,
    output logic            valid,
    output logic            done
);

    // Widest quantized word the precision field can request.
    localparam int QW = (1 << PRW) - 1;
    // Rounding adds one bit of headroom to the input word.
    localparam int RW = N + 1;
    // Saturation bounds need to hold both the rounded input and +/-2^(QW-1).
    localparam int SW = ((RW > QW + 1) ? RW : QW + 1) + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]            state;
    logic [PRW-1:0]        cnt;     // bits still to present after the current one
    logic [QW-1:0]         sreg;    // remaining bits, left-aligned
    logic                  accept;
    logic                  first_bit;
    logic [QW-1:0]         rest_bits;

    logic [31:0]           msb_c;
    logic [31:0]           prec;
    logic [31:0]           lsb;
    logic signed [RW-1:0]  sum;
    logic signed [SW-1:0]  shifted;
    logic signed [SW-1:0]  hi;
    logic signed [SW-1:0]  lo;
    logic signed [SW-1:0]  sat;
    logic [QW-1:0]         q;
    logic [QW-1:0]         aligned;

    // Ready is a pure function of state: idle, or presenting the last bit.
    assign rdy    = (state == IDLE) || done;
    assign accept = start && rdy && (oprec != '0);

    // Quantize the live inputs: clamp msbidx, round half-up, shift, saturate.
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        msb_c = 32'(msbidx);
        if (msb_c >= 32'(N)) begin
            msb_c = 32'(N - 1);
        end
        prec = 32'(oprec);
        lsb  = (msb_c + 32'd1 >= prec) ? (msb_c + 32'd1 - prec) : 32'd0;

        sum = {I[N-1], I};
        if (lsb != 32'd0) begin
            sum = sum + (RW'(1) << (lsb - 32'd1));
        end
        shifted = SW'(sum >>> lsb);

        hi  = (SW'(1) << (prec - 32'd1)) - SW'(1);
        lo  = -(SW'(1) << (prec - 32'd1));
        sat = shifted;
        if (shifted > hi) begin
            sat = hi;
        end else if (shifted < lo) begin
            sat = lo;
        end

        q         = QW'(sat);
        aligned   = q << (32'(QW) - prec);
        first_bit = aligned[QW-1];
        rest_bits = aligned << 1;
    end

    // Load a new word on acceptance, otherwise shift out the remaining bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            // NOTE: the shift register is a handful of flops, so it is reset along with the rest.
            sreg  <= '0;
            out   <= 1'b0;
            valid <= 1'b0;
            done  <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state <= SHIFT;
            cnt   <= oprec - PRW'(1);
            sreg  <= rest_bits;
            out   <= first_bit;
            valid <= 1'b1;
            done  <= (oprec == PRW'(1));
        end else if ((state == SHIFT) && (cnt != '0)) begin
            cnt   <= cnt - PRW'(1);
            sreg  <= sreg << 1;
            out   <= sreg[QW-1];
            valid <= 1'b1;
            done  <= (cnt == PRW'(1));
        end else begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
            out   <= 1'b0;
            valid <= 1'b0;
            done  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quant_serializer.sv
// Bench for quant_serializer: an arithmetic reference model builds the expected
// bit stream. A compare process checks every cycle, and directed words are
// checked against hand-computed patterns.
module tb_quant_serializer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] I;
    logic [4:0]  msbidx;
    logic [4:0]  oprec;
    logic        rdy;
    logic        out;
    logic        valid;
    logic        done;

    int total = 0;
    int bad   = 0;

    // Reference model state: queue of bits still to be presented.
    bit  pend[$];
    logic exp_valid = 1'b0;
    logic exp_out   = 1'b0;
    logic exp_done  = 1'b0;

    // Collected words from the DUT stream.
    logic [63:0] cur_word = '0;
    int          bits = 0;
    int          word_cnt = 0;
    int          valid_cycles = 0;
    logic [63:0] words [64];
    int          lens  [64];

    quant_serializer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .I      (I),
        .msbidx (msbidx),
        .oprec  (oprec),
        .rdy    (rdy),
        .out    (out),
        .valid  (valid),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Quantized word as an oprec-bit pattern, from plain integer arithmetic.
    function automatic longint model_q(input longint iv, input int msb, input int prec);
        int     m;
        int     lsb;
        longint d;
        longint v;
        longint f;
        longint hi;
        longint lo;
        m   = (msb >= 32) ? 31 : msb;
        lsb = (m + 1 >= prec) ? (m - prec + 1) : 0;
        d   = longint'(1) << lsb;
        v   = iv + ((lsb > 0) ? d / 2 : 0);
        f   = v / d;
        if ((v % d != 0) && (v < 0)) f = f - 1;
        hi  = (longint'(1) << (prec - 1)) - 1;
        lo  = -(longint'(1) << (prec - 1));
        if (f > hi) f = hi;
        if (f < lo) f = lo;
        return f & ((longint'(1) << prec) - 1);
    endfunction

    // Reference model: accept when idle or on the last bit, then emit MSB first.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            exp_valid <= 1'b0;
            exp_out   <= 1'b0;
            exp_done  <= 1'b0;
        end else begin
            automatic longint qv;
            automatic bit     nb;
            if (start && (!exp_valid || exp_done) && (oprec != 0)) begin
                qv = model_q(longint'($signed(I)), int'(msbidx), int'(oprec));
                for (int b = int'(oprec) - 1; b >= 0; b--) pend.push_back(qv[b]);
            end
            if (pend.size() > 0) begin
                nb = pend.pop_front();
                exp_out   <= nb;
                exp_valid <= 1'b1;
                exp_done  <= (pend.size() == 0);
            end else begin
                exp_out   <= 1'b0;
                exp_valid <= 1'b0;
                exp_done  <= 1'b0;
            end
        end
    end

    // Compare DUT against the model every cycle and collect finished words.
    always @(negedge clk) begin
        check("valid", valid, exp_valid);
        check("out",   out,   exp_out);
        check("done",  done,  exp_done);
        check("rdy",   rdy,   (!exp_valid || exp_done));
        if (valid) begin
            cur_word     <= {cur_word[62:0], out};
            bits         <= bits + 1;
            valid_cycles <= valid_cycles + 1;
            if (done) begin
                words[word_cnt] <= {cur_word[62:0], out};
                lens[word_cnt]  <= bits + 1;
                word_cnt        <= word_cnt + 1;
                cur_word        <= '0;
                bits            <= 0;
            end
        end else if (!rst_n) begin
            cur_word <= '0;
            bits     <= 0;
        end
    end

    task automatic send(input int iv, input int m, input int p);
        @(negedge clk);
        I      = 32'(iv);
        msbidx = 5'(m);
        oprec  = 5'(p);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_words(input int target);
        for (int c = 0; c < 100; c++) begin
            if (word_cnt >= target) break;
            @(negedge clk);
            #1;
        end
        check("word_arrived", word_cnt, target);
    endtask

    task automatic send_check(input string name, input int iv, input int m, input int p,
                              input longint exp, input int len);
        int tgt;
        tgt = word_cnt + 1;
        send(iv, m, p);
        wait_words(tgt);
        check(name, words[tgt-1], exp);
        check({name, "_len"}, lens[tgt-1], len);
        repeat (2) @(negedge clk);
    endtask

    initial begin : stim
        int b2b [9];
        int base;
        int vc0;
        int wc0;

        rst_n  = 1'b0;
        start  = 1'b0;
        I      = '0;
        msbidx = '0;
        oprec  = '0;
        #1;
        check("reset_valid", valid, 0);
        check("reset_out",   out,   0);
        check("reset_done",  done,  0);
        check("reset_rdy",   rdy,   1);

        // Pin the model against hand-computed values.
        check("model_25",   model_q(25, 7, 8),   64'h19);
        check("model_m45",  model_q(-45, 7, 8),  64'hD3);
        check("model_300",  model_q(300, 7, 8),  64'h7F);
        check("model_m300", model_q(-300, 7, 8), 64'h80);
        check("model_22",   model_q(22, 5, 4),   64'h6);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send_check("w_25",   25,   7, 8, 64'h19, 8);
        send_check("w_m45",  -45,  7, 8, 64'hD3, 8);
        send_check("w_300",  300,  7, 8, 64'h7F, 8);
        send_check("w_m300", -300, 7, 8, 64'h80, 8);
        send_check("w_22",   22,   5, 4, 64'h6,  4);
        send_check("p1_pos", 200,  7, 1, 64'h0,  1);
        send_check("p1_neg", -200, 7, 1, 64'h1,  1);

        // oprec=0 requests are ignored.
        I = 32'd25; msbidx = 5'd7; oprec = 5'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b1;
            #1;
            check("p0_valid", valid, 0);
            check("p0_rdy",   rdy,   1);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        check("p0_valid_end", valid, 0);

        // Start held high: words chain with no gap, mid-word starts ignored.
        b2b  = '{1, 3, 3, -2, 0, 0, 3, -1, -1};
        base = word_cnt;
        vc0  = valid_cycles;
        msbidx = 5'd2;
        oprec  = 5'd3;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            I     = 32'(b2b[k]);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        wait_words(base + 3);
        check("b2b_w0", words[base],   64'h1);
        check("b2b_w1", words[base+1], 64'h6);
        check("b2b_w2", words[base+2], 64'h3);
        check("b2b_valid_cycles", valid_cycles - vc0, 9);
        repeat (3) @(negedge clk);

        // Reset after the third of eight bits.
        send(25, 7, 8);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", valid, 0);
        check("rst_mid_out",   out,   0);
        check("rst_mid_done",  done,  0);
        check("rst_mid_rdy",   rdy,   1);
        vc0 = valid_cycles;
        wc0 = word_cnt;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        I      = 32'(-45);
        msbidx = 5'd7;
        oprec  = 5'd8;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_words(wc0 + 1);
        check("post_rst_word", words[wc0], 64'hD3);
        check("post_rst_len",  lens[wc0],  8);
        check("post_rst_valid_cycles", valid_cycles - vc0, 8);
        vc0 = valid_cycles;
        repeat (5) @(negedge clk);
        #1;
        check("quiet_after", valid_cycles, vc0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quant_serializer.md
QUANT_SERIALIZER -- requirements
Module: quant_serializer

Interface
REQ-001 The block SHALL have parameter N, default 32: input word width, matching the upstream maxpool output width.
REQ-002 The block SHALL have parameter IDXW, default 5: width of msbidx; selectable MSB positions 0..N-1.
REQ-003 The block SHALL have parameter PRW, default 5: width of oprec; output precision 1..2^PRW-1 bits.
REQ-004 Port clk, input, 1: single clock; all state on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port start, input, 1: request to quantize and serialize I.
REQ-007 Port I, input, N: signed two's-complement word from maxpool.
REQ-008 Port msbidx, input, IDXW: bit position of the window MSB in I.
REQ-009 Port oprec, input, PRW: output precision in bits.
REQ-010 Port rdy, output, 1: high when start will be accepted this cycle.
REQ-011 Port out, output, 1: serial output bit, MSB first.
REQ-012 Port valid, output, 1: out carries a valid bit.
REQ-013 Port done, output, 1: marks the last bit of a word, coincident with valid.

Function
REQ-014 The block SHALL implement two states: IDLE and SHIFT.
REQ-015 rdy SHALL be 1 in IDLE, and 1 in SHIFT only during the cycle done=1; otherwise 0.
REQ-016 A start SHALL be accepted on a rising edge with start=1, rdy=1 and oprec!=0. I, msbidx and oprec SHALL be sampled on that edge.
REQ-017 A start with oprec=0 SHALL be ignored; the state SHALL remain unchanged.
REQ-018 A start with rdy=0 SHALL be ignored; it SHALL NOT disturb the word in progress.
REQ-019 LSB index SHALL be lsb = msbidx-oprec+1 if msbidx+1 >= oprec, else 0.
REQ-020 Rounding SHALL be round-half-up: when lsb>0, 2^(lsb-1) is added to I in N+1-bit signed arithmetic before an arithmetic right shift by lsb.
REQ-021 The shifted value SHALL saturate to [-2^(oprec-1), 2^(oprec-1)-1]; the oprec-bit two's-complement result is the quantized word q.
REQ-022 q SHALL be computed and loaded into a shift register on the accepting edge.
REQ-023 After the accepting edge, out SHALL present q[oprec-1] with valid=1, then one lower bit per cycle, for exactly oprec consecutive cycles.
REQ-024 done SHALL be 1 only in the cycle carrying q[0]; for oprec=1, done SHALL be 1 in the first and only bit cycle.
REQ-025 After the last bit with no new start, the state SHALL return to IDLE; valid, done and out SHALL be 0 the next cycle.
REQ-026 A start accepted in the done cycle SHALL produce its MSB in the immediately following cycle, with no bubble in valid.
REQ-027 out SHALL be 0 whenever valid=0.
REQ-028 outputs out, valid and done SHALL be registered, with no combinational path from inputs.
REQ-029 rdy SHALL be combinational from state only.
REQ-030 Input values of msbidx >= N SHALL be treated as N-1.

Reset
REQ-031 When rst_n=0, the state SHALL be IDLE asynchronously; out=0, valid=0, done=0, rdy=1, and the bit counter and shift register SHALL be 0.
REQ-032 Reset during SHIFT SHALL abort the word; no further bits SHALL be emitted after reset is released.
REQ-033 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-034 Basic word: I=25, msbidx=7, oprec=8 -> out 0,0,0,1,1,0,0,1 on 8 consecutive valid cycles, with done on the 8th.
REQ-035 Negative value: I=-45, msbidx=7, oprec=8 -> 1,1,0,1,0,0,1,1 (0xD3).
REQ-036 Saturation at msbidx=7, oprec=8: I=300 -> 01111111, and I=-300 -> 10000000.
REQ-037 Rounding: I=22, msbidx=5, oprec=4 -> lsb=2, q=6, output 0,1,1,0. oprec=0 with start -> no valid and rdy stays 1.
REQ-038 Back-to-back and ignore: start held high continuously with oprec=3 -> contiguous 3-bit words with no valid gap; a start with different I mid-word SHALL NOT alter the current word.
REQ-039 Reset mid-shift: pull rst_n low after the 3rd of 8 bits -> valid, out and done are 0 immediately, rdy=1; no residual bits after release.
